// File: rtl/seq_check_monitor.sv
// seq_check_monitor: per-channel "trig |-> ##DELAY resp" checker with data bound check, sticky flags and saturating fail count (optional SEQ_MON_FIRST_FAIL_EN adds first-fail capture)
module seq_check_monitor #(
  parameter int NUM_CH   = 4,
  parameter int DELAY    = 2,
  parameter int DATA_W   = 8,
  parameter int DATA_MAX = 200,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_chk,
  input  logic              clear,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] resp,
  input  logic              data_vld,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [NUM_CH-1:0] fail_pulse,
  output logic [NUM_CH-1:0] fail_sticky,
  output logic              data_err,
  output logic              data_sticky,
  output logic [CNT_W-1:0]  fail_cnt
`ifdef SEQ_MON_FIRST_FAIL_EN
  ,
  output logic                                       first_vld,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] first_ch,
  output logic [15:0]                                first_ts
`endif
);
  localparam logic [DATA_W-1:0] DMAX = DATA_W'(DATA_MAX);
  localparam int SUM_W = CNT_W + 8;
  logic [DELAY-1:0]  pend [NUM_CH];
  logic [NUM_CH-1:0] fail_nxt;
  logic [NUM_CH-1:0] busy_v;
  logic [6:0]        pc;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              derr_nxt;
  // A violation is a pending obligation reaching the tail while resp is low
  always_comb begin
    fail_nxt = '0;
    busy_v   = '0;
    pc       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fail_nxt[c] = en_chk & pend[c][DELAY-1] & ~resp[c];
      busy_v[c]   = |pend[c];
      pc          = pc + 7'(fail_nxt[c]);
    end
    sum      = SUM_W'(clear ? '0 : fail_cnt) + SUM_W'(pc);
    cnt_nxt  = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
    derr_nxt = en_chk & data_vld & (data > DMAX);
  end
  assign busy = |busy_v;
  // Obligation shift registers; disabling checks flushes everything in flight
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      pend[c] <= (reset || !en_chk) ? '0 : ((pend[c] << 1) | DELAY'(trig[c]));
  end
  // Strobes, sticky flags and counter; clear wipes history before this edge's events land
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_pulse  <= '0;
      fail_sticky <= '0;
      data_err    <= 1'b0;
      data_sticky <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      fail_pulse  <= fail_nxt;
      fail_sticky <= (clear ? '0 : fail_sticky) | fail_nxt;
      data_err    <= derr_nxt;
      data_sticky <= (clear ? 1'b0 : data_sticky) | derr_nxt;
      fail_cnt    <= cnt_nxt;
    end
  end
`ifdef SEQ_MON_FIRST_FAIL_EN
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [15:0]     cyc;
  logic [CH_W-1:0] first_idx;
  // Lowest failing channel wins on simultaneous fails
  always_comb begin
    first_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (fail_nxt[c]) first_idx = CH_W'(c);
  end
  // Timestamp is the edge number since reset; capture only the first fail after reset/clear
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc       <= '0;
      first_vld <= 1'b0;
      first_ch  <= '0;
      first_ts  <= '0;
    end else begin
      cyc <= cyc + 16'd1;
      if (|fail_nxt && (!first_vld || clear)) begin
        first_vld <= 1'b1;
        first_ch  <= first_idx;
        first_ts  <= cyc + 16'd1;
      end else if (clear) begin
        first_vld <= 1'b0;
        first_ch  <= '0;
        first_ts  <= '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_seq_check_monitor.sv
// tb_seq_check_monitor: directed plus random checks of seq_check_monitor against an edge-history reference model
module tb_seq_check_monitor;
  localparam int NCH = 4, DL = 2, DW = 8, DMAX = 200, CW = 2, MSK = 8191;
  logic           clk = 1'b0;
  logic           reset = 1'b1, en_chk = 1'b0, clear = 1'b0, data_vld = 1'b0;
  logic [NCH-1:0] trig = '0, resp = '0;
  logic [DW-1:0]  data = '0;
  logic           busy, data_err, data_sticky;
  logic [NCH-1:0] fail_pulse, fail_sticky;
  logic [CW-1:0]  fail_cnt;
  int checks = 0, failures = 0, edge_n = 0, last_flush = 0;
  logic [NCH-1:0] th [0:MSK];
  logic [NCH-1:0] m_fp = '0, m_fs = '0;
  logic           m_de = 1'b0, m_ds = 1'b0, m_busy = 1'b0;
  int             m_cnt = 0;

  seq_check_monitor #(.NUM_CH(NCH), .DELAY(DL), .DATA_W(DW), .DATA_MAX(DMAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en_chk(en_chk), .clear(clear), .trig(trig), .resp(resp),
    .data_vld(data_vld), .data(data), .busy(busy), .fail_pulse(fail_pulse),
    .fail_sticky(fail_sticky), .data_err(data_err), .data_sticky(data_sticky), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock edge: drive, model the edge from the rules, then compare all outputs
  task automatic step(input logic rst, input logic en, input logic clr, input logic [NCH-1:0] tg,
                      input logic [NCH-1:0] rs, input logic dv, input logic [DW-1:0] d);
    logic [NCH-1:0] fv;
    @(negedge clk);
    reset = rst; en_chk = en; clear = clr; trig = tg; resp = rs; data_vld = dv; data = d;
    @(posedge clk);
    edge_n++;
    fv = '0;
    if (rst) begin
      last_flush = edge_n;
      m_fp = '0; m_fs = '0; m_de = 1'b0; m_ds = 1'b0; m_cnt = 0;
    end else begin
      if (en)
        for (int c = 0; c < NCH; c++)
          fv[c] = (edge_n - DL > last_flush) && th[(edge_n - DL) & MSK][c] && !rs[c];
      th[edge_n & MSK] = tg;
      if (!en) last_flush = edge_n;
      m_de  = en && dv && (d > DMAX);
      m_ds  = (clr ? 1'b0 : m_ds) | m_de;
      m_fp  = fv;
      m_fs  = (clr ? '0 : m_fs) | fv;
      m_cnt = (clr ? 0 : m_cnt) + $countones(fv);
      if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
    end
    m_busy = 1'b0;
    for (int t = edge_n - DL + 1; t <= edge_n; t++)
      if (t > last_flush && th[t & MSK] != '0) m_busy = 1'b1;
    #1;
    chk("fail_pulse", 32'(fail_pulse), 32'(m_fp));
    chk("fail_sticky", 32'(fail_sticky), 32'(m_fs));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_cnt));
    chk("data_err", 32'(data_err), 32'(m_de));
    chk("data_sticky", 32'(data_sticky), 32'(m_ds));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    for (int i = 0; i <= MSK; i++) th[i] = '0;
    // reset state
    step(1, 0, 0, '0, '0, 0, 0);
    step(1, 1, 0, '0, '0, 0, 0);
    chk("reset_cnt", 32'(fail_cnt), 0);
    chk("reset_busy", 32'(busy), 0);
    // 1: trig[0] answered on time
    step(0, 1, 0, 4'b0001, 4'b0000, 0, 0);
    chk("t1_busy_a", 32'(busy), 1);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    chk("t1_busy_b", 32'(busy), 1);
    step(0, 1, 0, 4'b0000, 4'b0001, 0, 0);
    chk("t1_nofail", 32'(fail_pulse), 0);
    chk("t1_busy_c", 32'(busy), 0);
    // 2: back-to-back trig[1], second obligation missed
    step(0, 1, 0, 4'b0010, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0010, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0000, 4'b0010, 0, 0);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    chk("t2_pulse", 32'(fail_pulse), 32'h2);
    chk("t2_cnt", 32'(fail_cnt), 1);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    chk("t2_pulse_once", 32'(fail_pulse), 0);
    chk("t2_sticky", 32'(fail_sticky), 32'h2);
    // 3: disable flushes pending obligation
    step(0, 1, 1, 4'b0001, 4'b0000, 0, 0);
    step(0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    chk("t3_busy", 32'(busy), 0);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    step(0, 1, 0, 4'b0000, 4'b0000, 0, 0);
    chk("t3_nofail", 32'(fail_sticky), 0);
    // 4: data bound, 200 legal, 210 not
    step(0, 1, 0, '0, '0, 1, 8'd200);
    chk("t4_200", 32'(data_err), 0);
    step(0, 1, 0, '0, '0, 1, 8'd210);
    chk("t4_210", 32'(data_err), 1);
    step(0, 1, 0, '0, '0, 0, 8'd255);
    chk("t4_sticky", 32'(data_sticky), 1);
    chk("t4_cnt", 32'(fail_cnt), 0);
    // 5: saturation then clear coincident with one fail
    step(0, 1, 1, 4'b1111, '0, 0, 0);
    step(0, 1, 0, 4'b0001, '0, 0, 0);
    step(0, 1, 0, 4'b0001, '0, 0, 0);
    step(0, 1, 0, 4'b0000, '0, 0, 0);
    chk("t5_sat", 32'(fail_cnt), 3);
    step(0, 1, 1, 4'b0000, '0, 0, 0);
    chk("t5_clear", 32'(fail_cnt), 1);
    chk("t5_clear_sticky", 32'(fail_sticky), 32'h1);
    // mid-obligation reset leaves nothing behind
    step(0, 1, 0, 4'b0100, '0, 0, 0);
    step(1, 1, 0, 4'b0000, '0, 0, 0);
    step(0, 1, 0, 4'b0000, '0, 0, 0);
    step(0, 1, 0, 4'b0000, '0, 0, 0);
    chk("rst_mid", 32'(fail_sticky), 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
           NCH'($urandom), NCH'($urandom | $urandom), 1'($urandom), DW'($urandom_range(150, 255)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
